// File: rtl/gon_apb_slv_mem_if.sv
// APB4 bus bundle between the bridge (master) and the memory completer (slave).
interface gon_apb_slv_mem_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pstrb, pprot, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pstrb, pprot, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/gon_apb_slv_mem.sv
// APB4 completer backed by a DEPTH x 32-bit register file with fixed wait states and byte strobes.
// Optional GON_APB_SLV_PROT_EN: unprivileged writes to the upper half of the array are rejected.
module gon_apb_slv_mem #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_CYC  = 1
) (
    input  logic               pclk,
    input  logic               preset,
    gon_apb_slv_mem_if.slave   i_apb
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, r_wdata;
    logic        r_write;
    logic [3:0]  r_strb;
    logic        r_pready, w_pready_nxt;
    logic        r_pslverr, w_pslverr_nxt;
    logic [31:0] r_prdata, w_prdata_nxt;
    logic [31:0] r_mem [DEPTH];

    logic          w_latch;
    logic          w_mem_we;
    logic [31:0]   w_addr;
    logic          w_write;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // In IDLE the attributes come straight off the bus so a zero-wait transfer can answer at its setup edge.
    assign w_addr  = (r_state == ST_IDLE) ? i_apb.paddr  : r_addr;
    assign w_write = (r_state == ST_IDLE) ? i_apb.pwrite : r_write;
    // BASE_ADDR is aligned to the array size, so the offset's index bits equal the address bits.
    assign w_idx   = w_addr[AW+1:2];

`ifdef GON_APB_SLV_PROT_EN
    logic [2:0] r_prot;
    logic [2:0] w_prot;
    assign w_prot = (r_state == ST_IDLE) ? i_apb.pprot : r_prot;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_prot <= '0;
        end else if (w_latch) begin
            r_prot <= i_apb.pprot;
        end
    end
`endif

    always_comb begin
        w_err = (w_addr[1:0] != 2'b00)
             || ({1'b0, w_addr} < {1'b0, BASE_ADDR})
             || ({1'b0, w_addr} >= LIMIT);
`ifdef GON_APB_SLV_PROT_EN
        if (w_write && !w_prot[0] && (w_idx >= AW'(DEPTH / 2))) begin
            w_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_latch       = 1'b0;
        w_mem_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_apb.psel && !i_apb.penable) begin
                    w_latch = 1'b1;
                    if (WAIT_CYC == 0) begin
                        w_state_nxt   = ST_DONE;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_err;
                        w_prdata_nxt  = (!w_write && !w_err) ? r_mem[w_idx] : 32'h0;
                    end else begin
                        w_cnt_nxt   = 4'(WAIT_CYC - 1);
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_apb.psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt   = ST_DONE;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = w_err;
                    w_prdata_nxt  = (!w_write && !w_err) ? r_mem[w_idx] : 32'h0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!i_apb.psel) begin
                    w_state_nxt   = ST_IDLE;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = 32'h0;
                end else if (i_apb.penable && r_pready) begin
                    w_mem_we      = r_write && !w_err;
                    w_state_nxt   = ST_IDLE;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = 32'h0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
                w_prdata_nxt  = 32'h0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_strb  <= '0;
        end else if (w_latch) begin
            r_addr  <= i_apb.paddr;
            r_wdata <= i_apb.pwdata;
            r_write <= i_apb.pwrite;
            r_strb  <= i_apb.pstrb;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign i_apb.pready  = r_pready;
    assign i_apb.pslverr = r_pslverr;
    assign i_apb.prdata  = r_prdata;
endmodule
